// File: rtl/computer_move_engine.sv
// computer_move_engine
//
// Automatic tic-tac-toe opponent that sits directly in front of the game top
// level and stands in for its manual computer_position / pc inputs.
//
// How a move is chosen:
//   1. start: the nine live cells are copied into a snapshot. Every later
//      decision reads only the snapshot.
//   2. WIN: lines L0..L7 are scanned one per cycle for two computer marks
//      plus one empty cell.
//   3. BLOCK: the same scan looks for two player marks plus one empty cell.
//   4. PREF: a fixed priority pick is made. The order is center, then the
//      corners, then the edges.
//   5. DRIVE: the chosen cell is driven on computer_position, and pc is held
//      high for PC_HOLD cycles.
//   6. DONE: done pulses for one cycle.
//   If the board has no empty cell, no_move pulses instead and nothing is
//   driven.
//
// Cell encoding: 00 empty, 01 player, 10 computer. The value 11 counts as
// occupied, but it belongs to neither mark.
//
// Handshake: a request is accepted only when start=1 at a rising edge while
// busy=0. busy stays high from the next cycle until the engine has returned
// to IDLE. A start seen while busy=1 is dropped, not queued. Each accepted
// request ends with exactly one done pulse or exactly one no_move pulse.
//
// Ports:
//   clock              system clock; all logic runs on the rising edge
//   reset              synchronous, active-high; aborts any operation
//   start              move request, sampled only in IDLE
//   pos1..pos9         live board cells (pos1 = index 0)
//   computer_position  chosen cell index 0..8; keeps its value until the next
//                      move or a reset
//   pc                 computer-play button; high only in DRIVE
//   busy               high whenever the engine is not in IDLE
//   done               one-cycle pulse after a move has been driven
//   no_move            one-cycle pulse when the board had no empty cell
//   state_dbg          current FSM state, for observation only
module computer_move_engine #(
    parameter int PC_HOLD = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] computer_position,
    output logic       pc,
    output logic       busy,
    output logic       done,
    output logic       no_move,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WIN   = 3'd1,
        BLOCK = 3'd2,
        PREF  = 3'd3,
        DRIVE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(PC_HOLD - 1);
    localparam logic [1:0] EMPTY     = 2'b00;

    state_t           state, state_next;
    logic [2:0]       line, line_next;
    logic [3:0]       hold, hold_next;
    logic [8:0][1:0]  snap, snap_next;
    logic [3:0]       position_next;

    // Evaluation of the line selected by the line counter.
    logic [3:0] idx_a, idx_b, idx_c;
    logic [1:0] cell_a, cell_b, cell_c;
    logic [1:0] mark;
    logic       line_hit;
    logic [3:0] hit_idx;

    // Priority pick used by PREF.
    logic       pref_found;
    logic [3:0] pref_idx;

    always_comb begin
        idx_a = 4'd0;
        idx_b = 4'd1;
        idx_c = 4'd2;
        case (line)
            3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
            3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
            3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
            3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
            3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
            3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
            3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
            default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
        endcase

        // One evaluator serves both scans. Only the mark being searched
        // for differs between WIN and BLOCK.
        mark   = (state == BLOCK) ? 2'b01 : 2'b10;
        cell_a = snap[idx_a];
        cell_b = snap[idx_b];
        cell_c = snap[idx_c];

        // "Exactly two equal the mark, third empty": a cell cannot be both
        // the mark and empty, so three pairwise patterns cover every case.
        line_hit = 1'b0;
        hit_idx  = idx_c;
        if (cell_a == mark && cell_b == mark && cell_c == EMPTY) begin
            line_hit = 1'b1;
            hit_idx  = idx_c;
        end else if (cell_a == mark && cell_c == mark && cell_b == EMPTY) begin
            line_hit = 1'b1;
            hit_idx  = idx_b;
        end else if (cell_b == mark && cell_c == mark && cell_a == EMPTY) begin
            line_hit = 1'b1;
            hit_idx  = idx_a;
        end
    end

    always_comb begin
        pref_found = 1'b1;
        pref_idx   = 4'd4;
        if      (snap[4] == EMPTY) pref_idx = 4'd4;
        else if (snap[0] == EMPTY) pref_idx = 4'd0;
        else if (snap[2] == EMPTY) pref_idx = 4'd2;
        else if (snap[6] == EMPTY) pref_idx = 4'd6;
        else if (snap[8] == EMPTY) pref_idx = 4'd8;
        else if (snap[1] == EMPTY) pref_idx = 4'd1;
        else if (snap[3] == EMPTY) pref_idx = 4'd3;
        else if (snap[5] == EMPTY) pref_idx = 4'd5;
        else if (snap[7] == EMPTY) pref_idx = 4'd7;
        else                       pref_found = 1'b0;
    end

    // Next-state and output logic.
    always_comb begin
        state_next    = state;
        line_next     = line;
        hold_next     = hold;
        snap_next     = snap;
        position_next = computer_position;
        pc            = 1'b0;
        done          = 1'b0;
        no_move       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    snap_next  = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
                    line_next  = 3'd0;
                    state_next = WIN;
                end
            end
            WIN, BLOCK: begin
                if (line_hit) begin
                    position_next = hit_idx;
                    hold_next     = 4'd0;
                    state_next    = DRIVE;
                end else if (line == 3'd7) begin
                    line_next  = 3'd0;
                    state_next = (state == WIN) ? BLOCK : PREF;
                end else begin
                    line_next = line + 3'd1;
                end
            end
            PREF: begin
                if (pref_found) begin
                    position_next = pref_idx;
                    hold_next     = 4'd0;
                    state_next    = DRIVE;
                end else begin
                    no_move    = 1'b1;
                    state_next = IDLE;
                end
            end
            DRIVE: begin
                pc = 1'b1;
                if (hold == HOLD_LAST) begin
                    state_next = DONE;
                end else begin
                    hold_next = hold + 4'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            line              <= 3'd0;
            hold              <= 4'd0;
            snap              <= '0;
            computer_position <= 4'd0;
        end else begin
            state             <= state_next;
            line              <= line_next;
            hold              <= hold_next;
            snap              <= snap_next;
            computer_position <= position_next;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_computer_move_engine.sv
// Directed testbench for computer_move_engine.
// Cycle numbering: cycle 1 is the first cycle after the edge that sampled
// start. Outputs are sampled 1 time unit after each rising edge.
module tb_computer_move_engine;

    localparam int PC_HOLD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [3:0] computer_position;
    logic       pc, busy, done, no_move;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    computer_move_engine #(.PC_HOLD(PC_HOLD)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .pos1              (pos1),
        .pos2              (pos2),
        .pos3              (pos3),
        .pos4              (pos4),
        .pos5              (pos5),
        .pos6              (pos6),
        .pos7              (pos7),
        .pos8              (pos8),
        .pos9              (pos9),
        .computer_position (computer_position),
        .pc                (pc),
        .busy              (busy),
        .done              (done),
        .no_move           (no_move),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_board(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                             input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5,
                             input logic [1:0] c6, input logic [1:0] c7, input logic [1:0] c8);
        pos1 = c0; pos2 = c1; pos3 = c2;
        pos4 = c3; pos5 = c4; pos6 = c5;
        pos7 = c6; pos8 = c7; pos9 = c8;
    endtask

    // Pulse start for one edge; afterwards the bench sits in cycle 1.
    task automatic start_move();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Walk from the current cycle through the done cycle, checking
    // pc/done/busy/computer_position against the expected timeline.
    task automatic expect_move(input logic [3:0] exp_pos, input int first);
        int last;
        last = first + PC_HOLD;
        while (cyc <= last) begin
            check("pc", 32'(pc), 32'(cyc >= first && cyc < last));
            check("done", 32'(done), 32'(cyc == last));
            check("no_move", 32'(no_move), 32'd0);
            check("busy", 32'(busy), 32'd1);
            if (cyc >= first && cyc < last)
                check("computer_position", 32'(computer_position), 32'(exp_pos));
            step();
        end
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
        check("pc_after", 32'(pc), 32'd0);
        check("pos_retained", 32'(computer_position), 32'(exp_pos));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        step();
        check("rst_pos", 32'(computer_position), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_no_move", 32'(no_move), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        step();

        // Win on L0: cell 2 completes two computer marks.
        set_board(2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        start_move();
        check("win_busy_c1", 32'(busy), 32'd1);
        check("win_pc_c1", 32'(pc), 32'd0);
        step();
        expect_move(4'd2, 2);

        // Block on L6 (0,4,8), found in cycle 15.
        set_board(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
        start_move();
        expect_move(4'd8, 16);

        // Full board with no empty cell: no_move in cycle 17, position stays 8.
        set_board(2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10);
        start_move();
        while (cyc <= 17) begin
            check("full_pc", 32'(pc), 32'd0);
            check("full_no_move", 32'(no_move), 32'(cyc == 17));
            check("full_done", 32'(done), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
            check("full_pos", 32'(computer_position), 32'd8);
            step();
        end
        check("full_busy_after", 32'(busy), 32'd0);
        check("full_no_move_after", 32'(no_move), 32'd0);
        check("full_pos_after", 32'(computer_position), 32'd8);

        // Empty board: preference picks the center.
        set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        start_move();
        expect_move(4'd4, 18);

        // Center taken by the player: first corner.
        set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        start_move();
        expect_move(4'd0, 18);

        // Cells of value 11 neither hit nor count as empty: corner 6 is chosen.
        set_board(2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        start_move();
        expect_move(4'd6, 18);

        // Snapshot and ignored restart: the board changes in cycle 3 to a
        // position that would win on L0, and start is re-pulsed in cycle 5.
        set_board(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
        start_move();
        step();
        step();
        set_board(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        expect_move(4'd8, 16);
        for (int i = 0; i < 4; i++) begin
            check("no_requeue_busy", 32'(busy), 32'd0);
            check("no_requeue_pc", 32'(pc), 32'd0);
            check("no_requeue_done", 32'(done), 32'd0);
            step();
        end

        // Reset in the first DRIVE cycle.
        set_board(2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        start_move();
        step();
        check("rst_drive_pc_before", 32'(pc), 32'd1);
        reset = 1'b1;
        step();
        check("rst_drive_pc", 32'(pc), 32'd0);
        check("rst_drive_busy", 32'(busy), 32'd0);
        check("rst_drive_pos", 32'(computer_position), 32'd0);
        check("rst_drive_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        // A start after the reset is accepted normally.
        start_move();
        step();
        expect_move(4'd2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
